// File: rtl/load_store_unit_pkg.sv
// Shared types and decode helpers for the load/store unit.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, BUS} lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    case (f3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends the addressed byte/half/word from a 32-bit bus read.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'd0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'd0, shifted[15:0]};
      F3_W:    result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding data-bus access, load formatting,
// and misalign/illegal/timeout error reporting.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_ack,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            err_valid,
  output logic [1:0]      err_cause
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      f3_reg, f3_next;
  logic [1:0]      off_reg, off_next;
  logic            req_next, we_next, rsp_valid_next, err_valid_next;
  logic [3:0]      be_next;
  logic [XLEN-1:0] addr_next, wdata_next, rsp_data_next, load_result;
  err_cause_t      cause_next;
  logic            timeout_hit;

  lsu_load_align u_align (
    .rdata  (dbus_rdata),
    .offset (off_reg),
    .funct3 (f3_reg),
    .result (load_result)
  );

  // TIMEOUT of 0 never fires; the counter simply wraps.
  assign timeout_hit = (TIMEOUT > 0) && (int'(cnt_reg) == TIMEOUT - 1);
  assign req_ready   = (state_reg == IDLE);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    f3_next        = f3_reg;
    off_next       = off_reg;
    req_next       = dbus_req;
    we_next        = dbus_we;
    addr_next      = dbus_addr;
    be_next        = dbus_be;
    wdata_next     = dbus_wdata;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data;
    err_valid_next = 1'b0;
    cause_next     = err_cause_t'(err_cause);
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (!f3_legal(req_we, req_funct3)) begin
            err_valid_next = 1'b1;
            cause_next     = ERR_ILLEGAL;
          end else if (addr_misaligned(req_funct3, req_addr[1:0])) begin
            err_valid_next = 1'b1;
            cause_next     = ERR_MISALIGN;
          end else begin
            state_next = BUS;
            cnt_next   = '0;
            f3_next    = req_funct3;
            off_next   = req_addr[1:0];
            req_next   = 1'b1;
            we_next    = req_we;
            addr_next  = {req_addr[XLEN-1:2], 2'b00};
            // Loads also get size-accurate byte enables.
            case (req_funct3[1:0])
              2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{req_wdata[15:0]}};
              end
              default: begin
                be_next    = 4'b1111;
                wdata_next = req_wdata;
              end
            endcase
          end
        end
      end
      BUS: begin
        if (dbus_ack) begin
          state_next     = IDLE;
          req_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_data_next  = dbus_we ? '0 : load_result;
        end else if (timeout_hit) begin
          state_next     = IDLE;
          req_next       = 1'b0;
          err_valid_next = 1'b1;
          cause_next     = ERR_TIMEOUT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      f3_reg     <= '0;
      off_reg    <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      err_valid  <= 1'b0;
      err_cause  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      f3_reg     <= f3_next;
      off_reg    <= off_next;
      dbus_req   <= req_next;
      dbus_we    <= we_next;
      dbus_addr  <= addr_next;
      dbus_be    <= be_next;
      dbus_wdata <= wdata_next;
      rsp_valid  <= rsp_valid_next;
      rsp_data   <= rsp_data_next;
      err_valid  <= err_valid_next;
      err_cause  <= cause_next;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit. Accepts one load or store per transaction from the execute/memory pipeline register.
- Drives a single-outstanding data-bus request and waits for the slave ack.
- Returns a formatted 32-bit load result. That result is the memory-data input of the writeback result-select mux (selector value 1).
- Flags misaligned accesses, illegal funct3 and bus timeouts to the hazard/trap logic.

Parameters:
- TIMEOUT, 16: max cycles in BUS state without ack before error; 0 disables the timeout.
- XLEN, 32: data/address width (only 32 supported).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request from pipeline
- req_ready  out  1  LSU can accept (state==IDLE)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 of load/store
- req_addr  in  32  effective byte address
- req_wdata  in  32  store source (rs2)
- dbus_req  out  1  bus request, held until ack/timeout
- dbus_we  out  1  bus write
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_ack  in  1  slave completion, single cycle
- dbus_rdata  in  32  read data, valid with ack
- rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- rsp_data  out  32  formatted load data; 0 for stores; held until next rsp_valid
- err_valid  out  1  one-cycle error pulse
- err_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout; held until next err_valid

Behaviour:
- Reset (async, rst=1): state=IDLE. dbus_req, dbus_we, rsp_valid, err_valid = 0. dbus_addr, dbus_be, dbus_wdata, rsp_data, err_cause = 0. Timeout counter = 0.
- Reset mid-transaction drops dbus_req immediately. A late ack after reset is ignored.
- States: IDLE, BUS.
- IDLE: req_ready=1. A request is accepted on a clock edge with req_valid=1.
  - Illegal funct3 (load: 011,110,111; store: any except 000,001,010): next cycle err_valid=1, err_cause=10; no bus access; stay IDLE.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): err_valid=1, err_cause=01; no bus access; stay IDLE.
  - Illegal funct3 takes priority over misaligned.
  - Otherwise: register dbus_* outputs, set dbus_req=1, go BUS, clear counter.
- BUS: req_ready=0. All dbus_* outputs stable until exit. Counter increments every cycle without ack.
  - dbus_ack=1: dbus_req=0 next cycle, rsp_valid=1 next cycle, rsp_data=formatted rdata (0 for store), go IDLE.
  - Counter reaches TIMEOUT-1 with no ack (TIMEOUT>0): dbus_req=0, err_valid=1 with err_cause=11, go IDLE.
  - Ack in the same cycle as timeout: ack wins.
- Latency: accept at edge E0, dbus_req visible after E0; ack sampled at edge Ek; rsp_valid high for the cycle after Ek. With a zero-wait slave (ack in first BUS cycle), rsp_valid is high 2 cycles after accept.
- Back-to-back: a new request may be accepted in the same IDLE cycle in which rsp_valid/err_valid is high.
- Store formatting:
  - SB: wdata={4{wdata[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - SW: be=4'b1111.
- Load formatting: shifted = rdata>>(8*addr[1:0]).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0].
  - LW: rdata.
- dbus_ack in IDLE is ignored.

Decomposition:
- Package riscv_lsu_pkg:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_t enum {IDLE, BUS}.
  - err_cause_t enum {ERR_NONE=0, ERR_MISALIGN=1, ERR_ILLEGAL=2, ERR_TIMEOUT=3}.
- Sub-module lsu_load_align (combinational: rdata, addr[1:0], funct3 -> 32-bit result). Instantiated once and reused by the bench as a checker.

Test Plan:
- SW addr=0x1000 wdata=0xDEADBEEF, ack in first BUS cycle -> dbus_addr=0x1000, be=1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_data=0.
- LB addr=0x2003, rdata=0x80FF_1234 -> rsp_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x2002 -> 0x000080FF.
- SB addr=0x3001 wdata=0x000000AB -> be=0010, dbus_wdata=0xABABABAB, dbus_addr=0x3000.
- LW addr=0x4002 -> err_valid one cycle, err_cause=01, dbus_req never asserts. Load funct3=011 -> err_cause=10.
- TIMEOUT=4, slave never acks -> dbus_req high exactly 4 cycles, then err_valid with cause 11, req_ready=1. Ack on the 4th cycle -> normal rsp_valid, no error.
- Assert rst during BUS with 3 wait states -> dbus_req falls without a clock edge; a subsequent ack produces no rsp_valid. A new LW after reset completes normally.
